powlib_busarbiter: RTL and testbench
====================================

Name: powlib_busarbiter

Overview:
- Round-robin arbiter and scheduler for one crossbar output lane.
- Selects among B_WRS valid/ready bus requesters whose address falls in the lane's window [B_BASE, B_BASE+B_SIZE].
- Grants the chosen requester a bounded burst and registers the winning data/address into a single output stage.
- Replaces the fixed-priority select in the lane; feeds the lane output FIFO, honouring its nearly-full flag.

Parameters:
- B_WRS, 4, number of requesters.
- B_AW, 2, address width.
- B_DW, 4, data width.
- B_BASE, 0, lowest address accepted by this lane.
- B_SIZE, 2, window span; highest accepted address is B_BASE+B_SIZE, computed in B_AW bits and inclusive.
- MAXBURST, 4, maximum consecutive beats granted to one owner before rotation; must be at least 1.

Ports:
- clk, input, 1, sole clock; all state is on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- wrdatas, input, B_WRS*B_DW, requester data; slice i is [i*B_DW +: B_DW].
- wraddrs, input, B_WRS*B_AW, requester addresses; slice i is [i*B_AW +: B_AW].
- wrvlds, input, B_WRS, requester valids.
- wrrdys, output, B_WRS, requester readies; combinational, at most one bit high.
- rddata, output, B_DW, registered output data.
- rdaddr, output, B_AW, registered output address.
- rdvld, output, 1, output valid.
- rdrdy, input, 1, downstream ready.
- rdnf, input, 1, downstream nearly full; blocks new accepts.
- grant, output, B_WRS, registered one-hot of the burst owner; 0 when IDLE.

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous, active-high.
- On reset: rdvld=0, grant=0, state=IDLE, beat count=0, ptr=B_WRS-1 (requester 0 wins first). rddata/rdaddr are not reset.
- Eligibility: elig[i] = wrvlds[i] && wraddrs[i] >= B_BASE && wraddrs[i] <= B_HIGH.
  - Out-of-window requests are never granted and never see wrrdys high.
- Load enable: load = (!rdvld || rdrdy) && !rdnf.
- Current selection, cur:
  - IDLE: first i with elig[i], searching cyclically from ptr+1.
  - HOLD: owner.
- wrrdys[i] = (i==cur) && elig[i] && load. A transfer (xfer) is wrvlds[i] && wrrdys[i].
- Output stage:
  - On xfer, the next cycle has rddata/rdaddr = the requester's slice and rdvld=1.
  - Otherwise, if rdrdy, rdvld goes 0 next cycle.
  - Otherwise rddata, rdaddr and rdvld hold.
  - Latency is exactly 1 cycle; throughput is 1 beat/cycle when rdrdy=1 and rdnf=0.
- State machine, IDLE:
  - On xfer from cur: if MAXBURST==1, stay IDLE and set ptr=cur. Else go HOLD with owner=cur, count=1, grant=onehot(cur).
  - No xfer (nothing eligible, or blocked by load=0): stay IDLE, ptr unchanged.
- State machine, HOLD:
  - xfer and count+1 == MAXBURST: go IDLE, ptr=owner, grant=0.
  - xfer otherwise: count increments.
  - elig[owner]==0: go IDLE, ptr=owner, grant=0, no beat that cycle.
  - load==0 with owner still eligible: hold state and count; stall does not consume burst budget.
- Fairness: a requester that stays eligible is granted within (B_WRS-1)*MAXBURST accepted beats of other requesters.
- Simultaneous events:
  - rdrdy and xfer in the same cycle: the output register is replaced (drain and refill), with no bubble.
  - rdnf=1: no new accepts; an already valid output still drains on rdrdy.
  - rst mid-burst: everything returns to reset values next cycle; an in-flight output beat is dropped (rdvld=0).
- Width rules: B_HIGH wraps modulo 2^B_AW; the window must not wrap. count is clog2(MAXBURST+1) bits.

Test Plan:
- Reset, then wrvlds=0001, wraddrs slice0=1, data=A, rdrdy=1 -> wrrdys=0001 same cycle; rdvld=1, rddata=A, rdaddr=1 next cycle; grant=0001.
- All 4 requesters valid continuously, all addresses in window, MAXBURST=4, rdrdy=1 -> beats 0-3 from req0, 4-7 from req1, 8-11 from req2, 12-15 from req3, then req0 again; grant sequence 0001, 0010, 0100, 1000.
- req1 addr=3 with B_BASE=0, B_SIZE=2, req2 addr=2, both valid -> req1 never ready; only req2 data appears, addr=2.
- Owner req0 streaming, rdrdy low 3 cycles -> wrrdys=0, rddata/rdvld stable; burst resumes afterwards and still totals 4 beats from req0.
- rdnf=1 with req0 and req1 valid -> wrrdys=0000; pending rdvld drains on rdrdy, then rdvld=0; rdnf=0 resumes with the correct round-robin owner.
- rst asserted after the 2nd beat of a burst from req2 -> next cycle rdvld=0, grant=0; first grant after reset goes to req0 when all are valid.

Source files
------------

// File: rtl/powlib_busarbiter_if.sv
// Requester-side and downstream-side signals of one crossbar output lane.
// The arbiter takes the slave view; the requesters/FIFO side takes the master view.
interface powlib_busarbiter_if #(
    parameter int unsigned B_WRS = 4,
    parameter int unsigned B_AW  = 2,
    parameter int unsigned B_DW  = 4
) ();
    logic [B_WRS*B_DW-1:0] wrdatas;
    logic [B_WRS*B_AW-1:0] wraddrs;
    logic [B_WRS-1:0]      wrvlds;
    logic [B_WRS-1:0]      wrrdys;
    logic [B_DW-1:0]       rddata;
    logic [B_AW-1:0]       rdaddr;
    logic                  rdvld;
    logic                  rdrdy;
    logic                  rdnf;
    logic [B_WRS-1:0]      grant;

    modport slave (
        input  wrdatas, wraddrs, wrvlds, rdrdy, rdnf,
        output wrrdys, rddata, rdaddr, rdvld, grant
    );

    modport master (
        output wrdatas, wraddrs, wrvlds, rdrdy, rdnf,
        input  wrrdys, rddata, rdaddr, rdvld, grant
    );
endinterface

// File: rtl/powlib_busarbiter.sv
// Round-robin burst arbiter for one crossbar output lane: picks an in-window requester,
// grants it up to MAXBURST beats, and registers the winning beat into one output stage.
module powlib_busarbiter #(
    parameter int unsigned B_WRS    = 4,
    parameter int unsigned B_AW     = 2,
    parameter int unsigned B_DW     = 4,
    parameter int unsigned B_BASE   = 0,
    parameter int unsigned B_SIZE   = 2,
    parameter int unsigned MAXBURST = 4
) (
    input logic               clk,
    input logic               rst,
    powlib_busarbiter_if.slave bus
);
    localparam int unsigned PtrW = (B_WRS > 1) ? $clog2(B_WRS) : 1;
    localparam int unsigned CntW = $clog2(MAXBURST + 1);

    localparam logic [B_AW-1:0] BaseAddr = B_AW'(B_BASE);
    // Window never wraps, so addr is inside iff (addr - base) mod 2^B_AW <= B_HIGH - base.
    localparam logic [B_AW-1:0] SpanAddr = B_AW'(B_BASE + B_SIZE) - BaseAddr;
    localparam logic [PtrW-1:0] LastIdx  = PtrW'(B_WRS - 1);
    localparam logic [CntW-1:0] BurstMax = CntW'(MAXBURST);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] owner_q, owner_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [B_WRS-1:0] grant_q, grant_d;

    logic            rdvld_q;
    logic [B_DW-1:0] rddata_q;
    logic [B_AW-1:0] rdaddr_q;

    logic [B_WRS-1:0] elig;
    logic [B_AW-1:0]  addr_off;
    logic [PtrW-1:0]  cur, cand;
    int unsigned      sel_idx;
    logic             cur_vld, load, xfer;

    always_comb begin
        elig     = '0;
        addr_off = '0;
        for (int i = 0; i < B_WRS; i++) begin
            addr_off = bus.wraddrs[i*B_AW +: B_AW] - BaseAddr;
            elig[i]  = bus.wrvlds[i] && (addr_off <= SpanAddr);
        end
    end

    // Descending scan so the nearest eligible index after ptr is written last and wins.
    always_comb begin
        cur     = owner_q;
        cur_vld = 1'b0;
        cand    = '0;
        sel_idx = 0;
        if (state_q == StHold) begin
            cur_vld = elig[owner_q];
        end else begin
            for (int k = B_WRS; k >= 1; k--) begin
                sel_idx = int'(ptr_q) + k;
                if (sel_idx >= B_WRS) sel_idx = sel_idx - B_WRS;
                cand = PtrW'(sel_idx);
                if (elig[cand]) begin
                    cur     = cand;
                    cur_vld = 1'b1;
                end
            end
        end
    end

    assign load = (!rdvld_q || bus.rdrdy) && !bus.rdnf;
    assign xfer = cur_vld && load;

    always_comb begin
        bus.wrrdys = '0;
        if (xfer) bus.wrrdys[cur] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    if (MAXBURST == 1) begin
                        ptr_d = cur;
                    end else begin
                        state_d       = StHold;
                        owner_d       = cur;
                        cnt_d         = CntW'(1);
                        grant_d       = '0;
                        grant_d[cur]  = 1'b1;
                    end
                end
            end
            StHold: begin
                if (!elig[owner_q] || (xfer && (cnt_q + CntW'(1) == BurstMax))) begin
                    state_d = StIdle;
                    ptr_d   = owner_q;
                    cnt_d   = '0;
                    grant_d = '0;
                end else if (xfer) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= LastIdx;
            owner_q <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            rdvld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            if (xfer) rdvld_q <= 1'b1;
            else if (bus.rdrdy) rdvld_q <= 1'b0;
        end
    end

    // Output payload is qualified by rdvld, so it carries no reset.
    always_ff @(posedge clk) begin
        if (xfer) begin
            rddata_q <= bus.wrdatas[int'(cur)*B_DW +: B_DW];
            rdaddr_q <= bus.wraddrs[int'(cur)*B_AW +: B_AW];
        end
    end

    assign bus.rddata = rddata_q;
    assign bus.rdaddr = rdaddr_q;
    assign bus.rdvld  = rdvld_q;
    assign bus.grant  = grant_q;
endmodule

// File: tb/tb_powlib_busarbiter.sv
// Scoreboard bench for powlib_busarbiter: a round-robin burst model predicts readies, grants
// and output beats; a monitor pops expected beats whenever the output handshake completes.
module tb_powlib_busarbiter;
    localparam int unsigned NW   = 4;
    localparam int unsigned AW   = 2;
    localparam int unsigned DW   = 4;
    localparam int unsigned BASE = 0;
    localparam int unsigned SIZE = 2;
    localparam int unsigned MAXB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    powlib_busarbiter_if #(.B_WRS(NW), .B_AW(AW), .B_DW(DW)) bus ();

    powlib_busarbiter #(
        .B_WRS(NW), .B_AW(AW), .B_DW(DW), .B_BASE(BASE), .B_SIZE(SIZE), .MAXBURST(MAXB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: current owner (-1 when none), beats it has taken, last requester served.
    int       m_owner;
    int       m_used;
    int       m_last;
    bit       m_full;
    logic [NW-1:0] m_grant;
    bit       started = 0;
    bit       flush = 0;
    logic [AW+DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_used  = 0;
        m_last  = NW - 1;
        m_full  = 0;
        m_grant = '0;
    endtask

    task automatic step(input logic [NW-1:0] v, input logic [NW*AW-1:0] a,
                        input logic [NW*DW-1:0] d, input bit rdy, input bit nf, input bit r);
        bit            el[NW];
        int            w;
        int            ad;
        int            high;
        bit            ld;
        logic [NW-1:0] exp_wr;
        @(negedge clk);
        #1;
        if (flush) begin
            exp_q.delete();
            flush = 0;
        end
        if (started) begin
            chk("grant", 32'(bus.grant), 32'(m_grant));
            chk("rdvld", 32'(bus.rdvld), 32'(m_full));
        end
        bus.wrvlds  = v;
        bus.wraddrs = a;
        bus.wrdatas = d;
        bus.rdrdy   = rdy;
        bus.rdnf    = nf;
        rst         = r;
        #1;
        high = (BASE + SIZE) % (1 << AW);
        for (int i = 0; i < NW; i++) begin
            ad    = int'(a[i*AW +: AW]);
            el[i] = v[i] && (ad >= BASE) && (ad <= high);
        end
        ld = (!m_full || rdy) && !nf;
        w  = -1;
        if (m_owner >= 0) begin
            if (!el[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (ld) begin
                w = m_owner;
            end
        end else if (ld) begin
            for (int k = 1; k <= NW; k++) begin
                if (w < 0 && el[(m_last + k) % NW]) w = (m_last + k) % NW;
            end
        end
        exp_wr = '0;
        if (w >= 0) exp_wr[w] = 1'b1;
        if (started) chk("wrrdys", 32'(bus.wrrdys), 32'(exp_wr));
        if (r) begin
            model_reset();
            flush   = 1;
            started = 1;
        end else begin
            if (w >= 0) begin
                exp_q.push_back({a[w*AW +: AW], d[w*DW +: DW]});
                if (m_owner == w) begin
                    m_used++;
                    if (m_used == MAXB) begin
                        m_last  = w;
                        m_owner = -1;
                    end
                end else if (MAXB == 1) begin
                    m_last = w;
                end else begin
                    m_owner = w;
                    m_used  = 1;
                end
            end
            m_full  = (w >= 0) ? 1'b1 : (rdy ? 1'b0 : m_full);
            m_grant = '0;
            if (m_owner >= 0) m_grant[m_owner] = 1'b1;
        end
    endtask

    // Monitor: a beat leaves the output stage whenever rdvld and rdrdy meet before the edge.
    initial begin
        logic [AW+DW-1:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (started && bus.rdvld === 1'b1 && bus.rdrdy === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'({bus.rdaddr, bus.rddata}), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_addr", 32'(bus.rdaddr), 32'(e[AW+DW-1:DW]));
                    chk("beat_data", 32'(bus.rddata), 32'(e[DW-1:0]));
                end
            end
        end
    end

    initial begin
        logic [NW*AW-1:0] all_in;
        logic [NW*AW-1:0] win_mix;
        bus.wrvlds  = '0;
        bus.wraddrs = '0;
        bus.wrdatas = '0;
        bus.rdrdy   = 1'b0;
        bus.rdnf    = 1'b0;
        model_reset();

        step('0, '0, '0, 1'b1, 1'b0, 1'b1);
        step('0, '0, '0, 1'b1, 1'b0, 1'b1);

        // Single requester 0 at address 1, data A.
        step(4'b0001, 8'h01, 16'h000A, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step('0, '0, '0, 1'b1, 1'b0, 1'b0);

        // All four valid and in window: bursts of four rotating 0,1,2,3,0.
        all_in = {2'd2, 2'd1, 2'd0, 2'd1};
        for (int i = 0; i < 20; i++) step(4'b1111, all_in, 16'($urandom), 1'b1, 1'b0, 1'b0);

        // req1 out of window (addr 3), req2 in window (addr 2).
        win_mix = {2'd0, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 8; i++) step(4'b0110, win_mix, 16'($urandom), 1'b1, 1'b0, 1'b0);
        step('0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Owner streaming with a three-cycle downstream stall mid-burst.
        for (int i = 0; i < 9; i++)
            step(4'b0001, 8'h01, 16'($urandom), !(i >= 2 && i < 5), 1'b0, 1'b0);

        // Nearly-full blocks accepts while the pending beat drains.
        for (int i = 0; i < 4; i++) step(4'b0011, 8'h05, 16'($urandom), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(4'b0011, 8'h05, 16'($urandom), 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a req2 burst, then all requesters valid.
        for (int i = 0; i < 3; i++) step(4'b0100, 8'h20, 16'($urandom), 1'b1, 1'b0, 1'b0);
        step(4'b0100, 8'h20, 16'($urandom), 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(4'b1111, all_in, 16'($urandom), 1'b1, 1'b0, 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++)
            step(4'($urandom), 8'($urandom), 16'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 149) == 0);

        for (int i = 0; i < 4; i++) step('0, '0, '0, 1'b1, 1'b0, 1'b0);
        #5;
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
